// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, frame width and prescaler divisor.
`timescale 1ns/1ps
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick prescaler: one-cycle tick every DIV clocks (always high when DIV is 1).
`timescale 1ns/1ps
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divider counter 0..DIV-1; stays at 0 when DIV is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronises rxd, majority-votes three mid-bit samples and
// presents each byte with a ready/clear handshake plus framing and overrun pulses.
`timescale 1ns/1ps
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       uart_ready,
  output logic [7:0] uart_rx,
  input  logic       uart_clear,
  output logic       frame_err,
  output logic       overrun
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BIW = $clog2(DATA_BITS);
  localparam logic [SCW-1:0] SC_V0   = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_V1   = SCW'(OVERSAMPLE / 2);
  localparam logic [SCW-1:0] SC_V2   = SCW'(OVERSAMPLE / 2 + 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [BIW-1:0] BI_LAST = BIW'(DATA_BITS - 1);

  logic                 sync1;
  logic                 rxs;
  logic                 tick;
  rx_state_t            state;
  rx_state_t            state_next;
  logic [SCW-1:0]       sc;
  logic [BIW-1:0]       bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 vote_a;
  logic                 vote_b;
  logic                 vote;
  logic                 at_vote;
  logic                 at_wrap;
  logic                 done_ok;
  logic                 stop_bad;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Two-flop synchroniser on the asynchronous pin, idling high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  assign vote    = (vote_a & vote_b) | (vote_a & rxs) | (vote_b & rxs);
  assign at_vote = tick && (sc == SC_V2);
  assign at_wrap = tick && (sc == SC_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and stop-bit outcome strobes.
  always_comb begin
    state_next = state;
    done_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE:  if (tick && !rxs) state_next = START;
      START: begin
        if (at_vote && vote) state_next = IDLE;
        else if (at_wrap)    state_next = DATA;
      end
      DATA:  if (at_wrap && (bit_idx == BI_LAST)) state_next = STOP;
      STOP: begin
        if (at_vote) begin
          if (vote) begin
            done_ok    = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: if (tick && rxs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sample counter, vote samples, bit index and shift register, all tick-paced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc      <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      vote_a  <= 1'b1;
      vote_b  <= 1'b1;
    end else if (tick) begin
      if (state == IDLE || state_next == IDLE || state_next == BREAK) begin
        sc <= '0;
      end else begin
        sc <= sc + 1'b1;
      end
      if (sc == SC_V0) vote_a <= rxs;
      if (sc == SC_V1) vote_b <= rxs;
      if (state == DATA && sc == SC_V2) begin
        shreg <= {vote, shreg[DATA_BITS-1:1]};
      end
      if (state == START) begin
        bit_idx <= '0;
      end else if (state == DATA && sc == SC_LAST) begin
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // Output registers; a completing byte beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_ready <= 1'b0;
      uart_rx    <= '0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= done_ok && uart_ready && !uart_clear;
      if (done_ok) begin
        uart_ready <= 1'b1;
        uart_rx    <= shreg;
      end else if (uart_clear) begin
        uart_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int OS       = 16;
  localparam int BIT_NS   = 160;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       uart_ready;
  logic [7:0] uart_rx;
  logic       uart_clear;
  logic       frame_err;
  logic       overrun;
  logic       clear_drv;
  logic       auto_clear;

  int passed = 0;
  int total  = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int cyc      = 0;
  int obs_cyc  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic       rdy_prev = 1'b0;
  logic [7:0] rx_prev  = 8'h00;

  assign uart_clear = auto_clear ? uart_ready : clear_drv;

  always #5 clk = ~clk;

  uart_receiver #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .uart_ready(uart_ready),
    .uart_rx   (uart_rx),
    .uart_clear(uart_clear),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always @(posedge clk) cyc++;

  // Capture each newly presented byte and count status pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (uart_ready === 1'b1 && (rdy_prev !== 1'b1 || uart_rx !== rx_prev)) begin
        obs_q.push_back(uart_rx);
        obs_cyc = cyc;
      end
      if (frame_err === 1'b1) ferr_cnt++;
      if (overrun === 1'b1) ovr_cnt++;
      rdy_prev = uart_ready;
      rx_prev  = uart_rx;
    end
  end

  task automatic send_frame(input logic [7:0] d, input int bit_ns, input bit stop_val,
                            input int stop_ns, input bit push);
    if (push) exp_q.push_back(d);
    rxd = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      #(bit_ns);
    end
    rxd = stop_val;
    #(stop_ns);
    rxd = 1'b1;
  endtask

  task automatic wait_obs(input int n, input int budget);
    int b;
    b = budget;
    while (obs_q.size() < n && b > 0) begin
      @(negedge clk);
      b--;
    end
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #1 clear_drv = 1'b1;
    @(posedge clk);
    #1 clear_drv = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rxd = 1'b1; clear_drv = 1'b0; auto_clear = 1'b0;
    #23;
    total++; if (uart_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", uart_ready); else passed++;
    total++; if (uart_rx !== 8'h00) $display("FAIL reset_rx: got %h expected 00", uart_rx); else passed++;
    total++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", frame_err); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL reset_ovr: got %b expected 0", overrun); else passed++;
    @(negedge clk);
    rst = 1'b0;
    #(BIT_NS * 2);
  endtask

  task automatic test_single_byte();
    logic [7:0] e, g;
    int t0;
    ferr_cnt = 0;
    @(posedge clk);
    #1 t0 = cyc;
    send_frame(8'h5A, BIT_NS, 1'b1, BIT_NS, 1'b1);
    wait_obs(1, 400);
    total++;
    if (obs_q.size() == 0) begin
      $display("FAIL single_byte: got none expected 5a");
    end else begin
      e = exp_q.pop_front(); g = obs_q.pop_front();
      if (g !== e) $display("FAIL single_byte: got %h expected %h", g, e); else passed++;
    end
    total++;
    if (obs_cyc - t0 < 150 || obs_cyc - t0 > 160)
      $display("FAIL single_latency: got %0d expected 150..160", obs_cyc - t0);
    else passed++;
    total++; if (ferr_cnt != 0) $display("FAIL single_ferr: got %0d expected 0", ferr_cnt); else passed++;
    repeat (5) @(negedge clk);
    total++; if (uart_ready !== 1'b1) $display("FAIL single_hold: got %b expected 1", uart_ready); else passed++;
    pulse_clear();
    total++; if (uart_ready !== 1'b0) $display("FAIL single_clear: got %b expected 0", uart_ready); else passed++;
  endtask

  task automatic test_false_start();
    logic [7:0] e, g;
    ferr_cnt = 0;
    rxd = 1'b0;
    #50;
    rxd = 1'b1;
    #(BIT_NS * 30);
    total++; if (obs_q.size() != 0) $display("FAIL glitch_byte: got %0d bytes expected 0", obs_q.size()); else passed++;
    total++; if (ferr_cnt != 0) $display("FAIL glitch_ferr: got %0d expected 0", ferr_cnt); else passed++;
    send_frame(8'hA5, BIT_NS, 1'b1, BIT_NS, 1'b1);
    wait_obs(1, 400);
    total++;
    if (obs_q.size() == 0) begin
      $display("FAIL after_glitch: got none expected a5");
    end else begin
      e = exp_q.pop_front(); g = obs_q.pop_front();
      if (g !== e) $display("FAIL after_glitch: got %h expected %h", g, e); else passed++;
    end
    pulse_clear();
  endtask

  task automatic test_frame_error();
    logic [7:0] e, g;
    ferr_cnt = 0;
    send_frame(8'h33, BIT_NS, 1'b0, BIT_NS * 3, 1'b0);
    #(BIT_NS * 3);
    total++; if (ferr_cnt != 1) $display("FAIL ferr_pulse: got %0d expected 1", ferr_cnt); else passed++;
    total++; if (obs_q.size() != 0) $display("FAIL ferr_byte: got %0d bytes expected 0", obs_q.size()); else passed++;
    total++; if (uart_ready !== 1'b0) $display("FAIL ferr_ready: got %b expected 0", uart_ready); else passed++;
    send_frame(8'h81, BIT_NS, 1'b1, BIT_NS, 1'b1);
    wait_obs(1, 400);
    total++;
    if (obs_q.size() == 0) begin
      $display("FAIL after_ferr: got none expected 81");
    end else begin
      e = exp_q.pop_front(); g = obs_q.pop_front();
      if (g !== e) $display("FAIL after_ferr: got %h expected %h", g, e); else passed++;
    end
    total++; if (ferr_cnt != 1) $display("FAIL ferr_recover: got %0d expected 1", ferr_cnt); else passed++;
    pulse_clear();
  endtask

  task automatic test_overrun();
    logic [7:0] e, g;
    ovr_cnt = 0;
    send_frame(8'h11, BIT_NS, 1'b1, BIT_NS, 1'b1);
    send_frame(8'h22, BIT_NS, 1'b1, BIT_NS, 1'b1);
    wait_obs(2, 400);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs_q.size() == 0) begin
        $display("FAIL overrun_byte%0d: got none expected byte", i);
      end else begin
        e = exp_q.pop_front(); g = obs_q.pop_front();
        if (g !== e) $display("FAIL overrun_byte%0d: got %h expected %h", i, g, e); else passed++;
      end
    end
    total++; if (ovr_cnt != 1) $display("FAIL overrun_pulse: got %0d expected 1", ovr_cnt); else passed++;
    total++; if (uart_rx !== 8'h22) $display("FAIL overrun_rx: got %h expected 22", uart_rx); else passed++;
    total++; if (uart_ready !== 1'b1) $display("FAIL overrun_ready: got %b expected 1", uart_ready); else passed++;
    pulse_clear();
  endtask

  task automatic test_tie_break();
    logic [7:0] e, g;
    ovr_cnt = 0;
    @(posedge clk);
    // Frames start 1 ns after this edge; the second byte completes on edge 317.
    fork
      begin
        #1;
        send_frame(8'h44, BIT_NS, 1'b1, BIT_NS, 1'b1);
        send_frame(8'h66, BIT_NS, 1'b1, BIT_NS, 1'b1);
      end
      begin
        repeat (316) @(posedge clk);
        #1 clear_drv = 1'b1;
        @(posedge clk);
        #1 clear_drv = 1'b0;
        @(negedge clk);
        total++; if (uart_ready !== 1'b1) $display("FAIL tie_ready: got %b expected 1", uart_ready); else passed++;
        total++; if (uart_rx !== 8'h66) $display("FAIL tie_rx: got %h expected 66", uart_rx); else passed++;
        @(negedge clk);
        total++; if (uart_ready !== 1'b1) $display("FAIL tie_hold: got %b expected 1", uart_ready); else passed++;
      end
    join
    wait_obs(2, 100);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs_q.size() == 0) begin
        $display("FAIL tie_byte%0d: got none expected byte", i);
      end else begin
        e = exp_q.pop_front(); g = obs_q.pop_front();
        if (g !== e) $display("FAIL tie_byte%0d: got %h expected %h", i, g, e); else passed++;
      end
    end
    total++; if (ovr_cnt != 0) $display("FAIL tie_overrun: got %0d expected 0", ovr_cnt); else passed++;
    pulse_clear();
  endtask

  task automatic test_baud_tolerance();
    logic [7:0] e, g;
    logic [7:0] pat [3];
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h55;
    ferr_cnt = 0; ovr_cnt = 0;
    auto_clear = 1'b1;
    for (int i = 0; i < 3; i++) send_frame(pat[i], 155, 1'b1, 155, 1'b1);
    wait_obs(3, 600);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs_q.size() == 0) begin
        $display("FAIL fast_byte%0d: got none expected byte", i);
      end else begin
        e = exp_q.pop_front(); g = obs_q.pop_front();
        if (g !== e) $display("FAIL fast_byte%0d: got %h expected %h", i, g, e); else passed++;
      end
    end
    total++; if (ferr_cnt != 0) $display("FAIL fast_ferr: got %0d expected 0", ferr_cnt); else passed++;
    total++; if (ovr_cnt != 0) $display("FAIL fast_ovr: got %0d expected 0", ovr_cnt); else passed++;
    total++; if (uart_ready !== 1'b0) $display("FAIL fast_pulse: got %b expected 0", uart_ready); else passed++;
    auto_clear = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] e, g;
    send_frame(8'h3C, BIT_NS, 1'b1, BIT_NS, 1'b1);
    wait_obs(1, 400);
    total++;
    if (obs_q.size() == 0) begin
      $display("FAIL pre_reset_byte: got none expected 3c");
    end else begin
      e = exp_q.pop_front(); g = obs_q.pop_front();
      if (g !== e) $display("FAIL pre_reset_byte: got %h expected %h", g, e); else passed++;
    end
    fork
      send_frame(8'hC3, BIT_NS, 1'b1, BIT_NS, 1'b0);
    join_none
    #503;
    rst = 1'b1;
    #1;
    total++; if (uart_ready !== 1'b0) $display("FAIL mid_rst_ready: got %b expected 0", uart_ready); else passed++;
    total++; if (uart_rx !== 8'h00) $display("FAIL mid_rst_rx: got %h expected 00", uart_rx); else passed++;
    #30;
    rst = 1'b0;
    wait fork;
    #(BIT_NS * 30);
    pulse_clear();
    obs_q.delete();
    #(BIT_NS * 2);
    send_frame(8'h96, BIT_NS, 1'b1, BIT_NS, 1'b1);
    wait_obs(1, 400);
    total++;
    if (obs_q.size() == 0) begin
      $display("FAIL post_reset_byte: got none expected 96");
    end else begin
      e = exp_q.pop_front(); g = obs_q.pop_front();
      if (g !== e) $display("FAIL post_reset_byte: got %h expected %h", g, e); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_false_start();
    test_frame_error();
    test_overrun();
    test_tie_break();
    test_baud_tolerance();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
